// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

    localparam int DATA_W          = 32;
    localparam int ADDR_W          = 32;
    localparam int BE_W            = DATA_W / 8;
    localparam int DEPTH_WORDS_DEF = 1024;
    localparam int LATENCY_DEF     = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Misaligned or beyond the end of the backing array.
    function automatic logic addr_faults(input logic [ADDR_W-1:0] addr, input int depth);
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and the memory responder.
// Latency: n/a (wires only).
// Backpressure: req_ready gates acceptance; responses are single-cycle pulses with no stall.
// Signals: req_valid/req_ready/req_we/req_addr/req_wdata/req_be, rsp_valid/rsp_rdata/rsp_err.
interface mem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_array.sv
// Single-port byte-enabled RAM, synchronous write, registered read, no reset.
// Latency: read data appears on rdata_o one cycle after an enabled read.
// Backpressure: none; an access is performed on every edge with en_i=1.
// Ports: clk, en_i, we_i, addr_i (word index), wdata_i, be_i, rdata_o.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_WORDS_DEF,
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request, waits LATENCY cycles, accesses mem_array, pulses a response.
// Latency: rsp_valid LATENCY+1 cycles after the accept cycle; one request per LATENCY+2 cycles.
// Backpressure: req_ready is high only in IDLE; responses cannot be stalled.
// Ports: clk, reset (sync, active-low), bus (mem_responder_if.slave).
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int LATENCY     = LATENCY_DEF
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              err_q;

    logic              accept;
    logic              enter_resp;
    logic              fault_now;
    logic              in_idle;
    logic              sel_we;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic              sel_err;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;

    assign fault_now = addr_faults(bus.req_addr, DEPTH_WORDS);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    cnt_d  = CNT_W'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Counter hits zero on this edge: the access happens now.
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With LATENCY=0 the array is accessed on the accept edge itself, before the
    // capture registers are loaded, so the live request feeds the array in IDLE.
    assign in_idle   = (state_q == IDLE);
    assign sel_we    = in_idle ? bus.req_we                  : we_q;
    assign sel_idx   = in_idle ? bus.req_addr[IDX_W+1:2]     : idx_q;
    assign sel_wdata = in_idle ? bus.req_wdata               : wdata_q;
    assign sel_be    = in_idle ? bus.req_be                  : be_q;
    assign sel_err   = in_idle ? fault_now                   : err_q;

    // Reset low on the would-be commit edge abandons the access.
    assign ram_en = reset && enter_resp && !sel_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                idx_q   <= bus.req_addr[IDX_W+1:2];
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
                err_q   <= fault_now;
            end
        end
    end

    mem_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (sel_we),
        .addr_i  (sel_idx),
        .wdata_i (sel_wdata),
        .be_i    (sel_be),
        .rdata_o (ram_rdata)
    );

    // Response fields are forced to zero outside RESP, and rdata is zero for writes and faults.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=2 instance driven from a vector table, LATENCY=0 instance
// driven back-to-back, plus reset-abort sequence. Expected responses go through scoreboard queues.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks;
    int   n_fail;
    exp_t sb_a [$];
    exp_t sb_b [$];
    vec_t va [16];
    vec_t vb [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on the LATENCY=2 port; inputs are scrambled right after acceptance.
    task automatic issue_a(input vec_t v, input string tag);
        int   cyc;
        exp_t e;
        chk({tag, "_ready_idle"}, 32'(bus_a.req_ready), 32'd1);
        bus_a.req_we    = v.we;
        bus_a.req_addr  = v.addr;
        bus_a.req_wdata = v.wdata;
        bus_a.req_be    = v.be;
        bus_a.req_valid = 1'b1;
        sb_a.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        tick();
        bus_a.req_valid = 1'b0;
        bus_a.req_we    = ~v.we;
        bus_a.req_addr  = ~v.addr;
        bus_a.req_wdata = $urandom;
        bus_a.req_be    = ~v.be;
        cyc = 1;
        while (!bus_a.rsp_valid && cyc < 40) begin
            chk({tag, "_ready_busy"}, 32'(bus_a.req_ready), 32'd0);
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(LAT_A + 1));
        chk({tag, "_ready_resp"}, 32'(bus_a.req_ready), 32'd0);
        if (sb_a.size() > 0) begin
            e = sb_a.pop_front();
            chk({tag, "_rdata"}, bus_a.rsp_rdata, e.rdata);
            chk({tag, "_err"}, 32'(bus_a.rsp_err), 32'(e.err));
        end
        tick();
        chk({tag, "_valid_after"}, 32'(bus_a.rsp_valid), 32'd0);
        chk({tag, "_ready_after"}, 32'(bus_a.req_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        int   bi;
        int   last_acc;
        int   got;
        exp_t e;

        n_checks = 0;
        n_fail   = 0;

        va[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        va[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        va[2]  = '{1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,        1'b0};
        va[3]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDE22BE44, 1'b0};
        va[4]  = '{1'b0, 32'h13,   32'h0,        4'hF, 32'h0,        1'b1};
        va[5]  = '{1'b0, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b1};
        va[6]  = '{1'b1, 32'h13,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        va[7]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        va[8]  = '{1'b1, 32'h10,   32'h00000000, 4'h0, 32'h0,        1'b0};
        va[9]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        va[10] = '{1'b1, 32'hFFC,  32'h12345678, 4'hF, 32'h0,        1'b0};
        va[11] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h12345678, 1'b0};
        va[12] = '{1'b1, 32'h14,   32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
        va[13] = '{1'b1, 32'h14,   32'h00000000, 4'hA, 32'h0,        1'b0};
        va[14] = '{1'b0, 32'h14,   32'h0,        4'h0, 32'h00BB00DD, 1'b0};
        va[15] = '{1'b1, 32'h80000010, 32'h0,    4'hF, 32'h0,        1'b1};

        vb[0] = '{1'b1, 32'h0, 32'h5A5A0001, 4'hF, 32'h0,        1'b0};
        vb[1] = '{1'b1, 32'h4, 32'h0BADF00D, 4'hF, 32'h0,        1'b0};
        vb[2] = '{1'b0, 32'h0, 32'h0,        4'h0, 32'h5A5A0001, 1'b0};
        vb[3] = '{1'b0, 32'h4, 32'h0,        4'h0, 32'h0BADF00D, 1'b0};
        vb[4] = '{1'b0, 32'h2, 32'h0,        4'h0, 32'h0,        1'b1};
        vb[5] = '{1'b0, 32'h0, 32'h0,        4'h0, 32'h5A5A0001, 1'b0};

        reset = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
        bus_a.req_wdata = '0;   bus_a.req_be = '0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
        bus_b.req_wdata = '0;   bus_b.req_be = '0;
        repeat (3) tick();

        chk("rst_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("rst_rdata", bus_a.rsp_rdata, 32'd0);
        chk("rst_err",   32'(bus_a.rsp_err), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_ready_a", 32'(bus_a.req_ready), 32'd1);
        chk("rst_ready_b", 32'(bus_b.req_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            issue_a(va[i], $sformatf("vec%0d", i));
        end

        // Reset during WAIT must abandon the pending write.
        v = '{1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0};
        issue_a(v, "pre20");
        bus_a.req_we = 1'b1; bus_a.req_addr = 32'h20;
        bus_a.req_wdata = 32'h0000CAFE; bus_a.req_be = 4'hF;
        bus_a.req_valid = 1'b1;
        tick();
        bus_a.req_valid = 1'b0;
        chk("abort_in_wait", 32'(bus_a.req_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_valid_rst", 32'(bus_a.rsp_valid), 32'd0);
        reset = 1'b1;
        tick();
        chk("abort_ready_rel", 32'(bus_a.req_ready), 32'd1);
        chk("abort_valid_rel", 32'(bus_a.rsp_valid), 32'd0);
        v = '{1'b0, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0};
        issue_a(v, "post20");

        // LATENCY=0: request held valid continuously.
        bi = 0; last_acc = -10; got = 0;
        bus_b.req_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && (bi < 6 || sb_b.size() > 0); cyc++) begin
            if (bus_b.rsp_valid) begin
                chk("b_ready_resp", 32'(bus_b.req_ready), 32'd0);
                chk("b_latency", 32'(cyc - last_acc), 32'd1);
                if (sb_b.size() > 0) begin
                    e = sb_b.pop_front();
                    chk("b_rdata", bus_b.rsp_rdata, e.rdata);
                    chk("b_err", 32'(bus_b.rsp_err), 32'(e.err));
                end
                got++;
            end
            if (bus_b.req_ready) begin
                if (bi < 6) begin
                    if (bi > 0) chk("b_spacing", 32'(cyc - last_acc), 32'd2);
                    bus_b.req_we    = vb[bi].we;
                    bus_b.req_addr  = vb[bi].addr;
                    bus_b.req_wdata = vb[bi].wdata;
                    bus_b.req_be    = vb[bi].be;
                    sb_b.push_back('{rdata: vb[bi].exp_rdata, err: vb[bi].exp_err});
                    last_acc = cyc;
                    bi++;
                end else begin
                    bus_b.req_valid = 1'b0;
                end
            end
            tick();
        end
        bus_b.req_valid = 1'b0;
        chk("b_resp_count", 32'(got), 32'd6);
        tick();
        chk("b_idle_valid", 32'(bus_b.rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 1024, number of 32-bit words in the backing array.
REQ-002 Parameter: LATENCY, default 2, wait-state cycles between request acceptance and array access (legal 0..15).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-005 Port: req_valid  input  1  requester presents a valid access.
REQ-006 Port: req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port: req_we  input  1  1 = write, 0 = read.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  write data.
REQ-010 Port: req_be  input  4  byte enables for writes; bit i enables byte lane i (bits 8i+7:8i).
REQ-011 Port: rsp_valid  output  1  one-cycle pulse marking a completed access.
REQ-012 Port: rsp_rdata  output  32  read data; valid only while rsp_valid=1.
REQ-013 Port: rsp_err  output  1  access faulted; valid only while rsp_valid=1.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 in IDLE and 0 in WAIT and RESP.
REQ-016 In IDLE, req_valid=1 SHALL accept the request: capture we/addr/wdata/be and load the wait counter with LATENCY.
REQ-017 After an accept with LATENCY>0, the FSM SHALL go to WAIT; with LATENCY=0 it SHALL go directly to RESP.
REQ-018 In WAIT, the counter SHALL decrement once per cycle; on the cycle it reaches 0, the FSM SHALL go to RESP.
REQ-019 The array access (write commit or read) SHALL occur on the clock edge that enters RESP.
REQ-020 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE.
REQ-021 Latency SHALL be LATENCY+1 cycles from the accept edge to the rsp_valid cycle.
REQ-022 Throughput SHALL be at most one request per LATENCY+2 cycles; a new request can be accepted on the cycle after RESP.
REQ-023 Writes SHALL update only the byte lanes whose req_be bit is 1.
REQ-024 A write with be=4'b0000 SHALL leave memory unchanged and still produce a response with rsp_err=0.
REQ-025 For a write, rsp_rdata SHALL be 0.
REQ-026 For a read, rsp_rdata SHALL be the full word at addr[31:2]; req_be is ignored on reads.
REQ-027 An access SHALL fault if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
REQ-028 A faulting access SHALL NOT modify memory and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-029 Input changes after acceptance SHALL have no effect on the access in flight.
REQ-030 rsp_valid, rsp_err and rsp_rdata SHALL be 0 whenever the FSM is not in RESP.

Reset
REQ-031 When reset=0 at a clock edge, the FSM SHALL go to IDLE, and the counter, rsp_valid, rsp_err and rsp_rdata SHALL become 0.
REQ-032 Reset asserted during WAIT SHALL abandon the pending access; a pending write SHALL NOT be committed.
REQ-033 Reset SHALL NOT clear array contents.
REQ-034 req_ready SHALL be 1 on the first cycle after reset is released.

Structure
REQ-035 Shared package mem_pkg SHALL hold the FSM state enum (IDLE/WAIT/RESP), the default DEPTH_WORDS and LATENCY, and the counter width constant (4 bits).
REQ-036 The array SHALL be one sub-module, mem_array: a single-port, byte-enabled, synchronous-write, registered-read RAM with no reset.
REQ-037 The FSM, counter, fault check and request capture registers SHALL live in mem_responder.

Verification
REQ-038 LATENCY=2: write addr 0x10, data 0xDEADBEEF, be=4'hF; then read 0x10 -> rsp_valid 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-039 Word 0x10 holds 0xDEADBEEF; write 0x11223344 with be=4'b0101; read 0x10 -> 0xDE22BE44.
REQ-040 Read addr 0x13, then read addr 4*DEPTH_WORDS -> each gives err=1, rdata=0; a write to 0x13 leaves word 0x10 unchanged.
REQ-041 LATENCY=0, req_valid held high for back-to-back reads -> accepts every 2nd cycle, rsp_valid 1 cycle after each accept, req_ready=0 in RESP.
REQ-042 Write 0x0000CAFE to 0x20, pull reset low during WAIT, then read 0x20 -> prior contents returned; rsp_valid=0 and req_ready=1 after reset release.
REQ-043 Change req_addr and req_wdata during WAIT -> response reflects the captured values only.
